// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared RV32 definitions: base opcodes, immediate-type select codes,
// instruction classes, write-back source codes and the multicycle
// controller state encoding. Imported by the controller, the class decoder
// and the immediate generator.
// ---------------------------------------------------------------------------
package riscv_pkg;

  // Base opcodes (inst[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // One-hot immediate select: bit4=I, bit3=S, bit2=B, bit1=J, bit0=U
  localparam logic [4:0] IMM_NONE = 5'b00000;
  localparam logic [4:0] IMM_I    = 5'b10000;
  localparam logic [4:0] IMM_S    = 5'b01000;
  localparam logic [4:0] IMM_B    = 5'b00100;
  localparam logic [4:0] IMM_J    = 5'b00010;
  localparam logic [4:0] IMM_U    = 5'b00001;

  // Write-back source select
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  // Control-flow class of an instruction; ALU covers OP, OP-IMM, LUI, AUIPC
  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_JUMP    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } inst_class_t;

endpackage

// File: rtl/inst_class_dec.sv
// ---------------------------------------------------------------------------
// inst_class_dec
// Combinational opcode decoder: maps inst[6:0] to an instruction class and
// the one-hot immediate-type select.
//   opcode_i   : inst[6:0]
//   class_o    : instruction class (CLS_ILLEGAL for unsupported opcodes)
//   imm_type_o : one-hot immediate select (IMM_NONE for R-type / illegal)
// ---------------------------------------------------------------------------
module inst_class_dec
  import riscv_pkg::*;
(
  input  logic [6:0]  opcode_i,
  output inst_class_t class_o,
  output logic [4:0]  imm_type_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a variable unassigned, which would infer a latch.
    class_o    = CLS_ILLEGAL;
    imm_type_o = IMM_NONE;
    case (opcode_i)
      OPC_LOAD:   begin class_o = CLS_LOAD;   imm_type_o = IMM_I; end
      OPC_OP_IMM: begin class_o = CLS_ALU;    imm_type_o = IMM_I; end
      OPC_JALR:   begin class_o = CLS_JUMP;   imm_type_o = IMM_I; end
      OPC_STORE:  begin class_o = CLS_STORE;  imm_type_o = IMM_S; end
      OPC_BRANCH: begin class_o = CLS_BRANCH; imm_type_o = IMM_B; end
      OPC_JAL:    begin class_o = CLS_JUMP;   imm_type_o = IMM_J; end
      OPC_LUI:    begin class_o = CLS_ALU;    imm_type_o = IMM_U; end
      OPC_AUIPC:  begin class_o = CLS_ALU;    imm_type_o = IMM_U; end
      OPC_OP:     begin class_o = CLS_ALU;    imm_type_o = IMM_NONE; end
      default:    ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for a multicycle RV32 datapath:
// FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, with a sticky TRAP on
// illegal opcodes or on a memory request waiting MEM_TIMEOUT cycles.
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   inst_i             : instruction register contents
//   mem_ready_i        : memory completion (only honoured in FETCH/MEM)
//   branch_taken_i     : ALU branch condition
//   imm_type_o         : one-hot immediate select, registered in DECODE
//   mem_req_o/mem_we_o : memory request / write
//   ir_we_o, reg_we_o, pc_we_o : IR, register file and PC load strobes
//   pc_sel_o           : 0 = PC+4, 1 = ALU target
//   wb_sel_o           : 00 = ALU, 01 = memory, 10 = PC+4
//   retire_o, trap_o   : instruction-complete pulse, sticky fault
//   state_o            : current state, for debug
// ---------------------------------------------------------------------------
module multicycle_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] inst_i,
  input  logic        mem_ready_i,
  input  logic        branch_taken_i,
  output logic [4:0]  imm_type_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        ir_we_o,
  output logic        reg_we_o,
  output logic        pc_we_o,
  output logic        pc_sel_o,
  output logic        retire_o,
  output logic        trap_o,
  output logic [1:0]  wb_sel_o,
  output logic [2:0]  state_o
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            r_state, w_state_next;
  inst_class_t       r_class, w_dec_class;
  logic [4:0]        r_imm_type, w_dec_imm;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              w_mem_phase, w_wait, w_timeout, w_enter_mem_phase;
  logic              w_unused_inst;

  inst_class_dec u_dec (
    .opcode_i   (inst_i[6:0]),
    .class_o    (w_dec_class),
    .imm_type_o (w_dec_imm)
  );

  // Operand fields are consumed by the datapath, not by this controller.
  assign w_unused_inst = ^inst_i[31:7];

  // A request is outstanding in FETCH and MEM; kept out of the output
  // process so the timeout term does not loop back through it.
  assign w_mem_phase = !rst_i && (r_state == ST_FETCH || r_state == ST_MEM);
  assign w_wait      = w_mem_phase && !mem_ready_i;
  // This wait cycle is the one that brings the count to MEM_TIMEOUT.
  assign w_timeout   = w_wait && (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign w_enter_mem_phase = (w_state_next != r_state) &&
                             (w_state_next == ST_FETCH || w_state_next == ST_MEM);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_FETCH;
      r_class    <= CLS_ALU;
      r_imm_type <= IMM_NONE;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      // Class and immediate select are captured once per instruction so
      // later states do not depend on inst_i staying stable.
      if (r_state == ST_DECODE) begin
        r_class    <= w_dec_class;
        r_imm_type <= w_dec_imm;
      end
      if (w_enter_mem_phase) begin
        r_wait_cnt <= '0;
      end else if (w_wait) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    ir_we_o      = 1'b0;
    reg_we_o     = 1'b0;
    pc_we_o      = 1'b0;
    pc_sel_o     = 1'b0;
    retire_o     = 1'b0;
    trap_o       = 1'b0;
    wb_sel_o     = WB_ALU;
    // Outputs are gated by reset so an aborted operation strobes nothing.
    if (!rst_i) begin
      case (r_state)
        ST_FETCH: begin
          mem_req_o = 1'b1;
          if (mem_ready_i) begin
            ir_we_o      = 1'b1;
            w_state_next = ST_DECODE;
          end else if (w_timeout) begin
            w_state_next = ST_TRAP;
          end
        end
        ST_DECODE: begin
          w_state_next = (w_dec_class == CLS_ILLEGAL) ? ST_TRAP : ST_EXEC;
        end
        ST_EXEC: begin
          case (r_class)
            CLS_LOAD, CLS_STORE: w_state_next = ST_MEM;
            CLS_BRANCH: begin
              pc_we_o      = 1'b1;
              pc_sel_o     = branch_taken_i;
              retire_o     = 1'b1;
              w_state_next = ST_FETCH;
            end
            default: w_state_next = ST_WB;
          endcase
        end
        ST_MEM: begin
          mem_req_o = 1'b1;
          mem_we_o  = (r_class == CLS_STORE);
          if (mem_ready_i) begin
            if (r_class == CLS_STORE) begin
              pc_we_o      = 1'b1;
              retire_o     = 1'b1;
              w_state_next = ST_FETCH;
            end else begin
              w_state_next = ST_WB;
            end
          end else if (w_timeout) begin
            w_state_next = ST_TRAP;
          end
        end
        ST_WB: begin
          reg_we_o     = 1'b1;
          pc_we_o      = 1'b1;
          retire_o     = 1'b1;
          w_state_next = ST_FETCH;
          case (r_class)
            CLS_LOAD: wb_sel_o = WB_MEM;
            CLS_JUMP: begin
              wb_sel_o = WB_PC4;
              pc_sel_o = 1'b1;
            end
            default:  wb_sel_o = WB_ALU;
          endcase
        end
        ST_TRAP: trap_o = 1'b1;
        default: w_state_next = ST_TRAP;
      endcase
    end
  end

  assign imm_type_o = r_imm_type;
  assign state_o    = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed and randomized checks of multicycle_ctrl (MEM_TIMEOUT = 4).
// Each instruction is expanded by a reference model into a per-cycle list
// of (ready, branch_taken, expected strobes) built from the instruction
// class and the requested memory wait counts, then replayed on the DUT.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;
  import riscv_pkg::*;

  localparam int TIMEOUT = 4;

  // Expected-strobe vector layout
  localparam logic [9:0] B_REQ   = 10'b10_0000_0000;
  localparam logic [9:0] B_WE    = 10'b01_0000_0000;
  localparam logic [9:0] B_IR    = 10'b00_1000_0000;
  localparam logic [9:0] B_REGWE = 10'b00_0100_0000;
  localparam logic [9:0] B_PCWE  = 10'b00_0010_0000;
  localparam logic [9:0] B_PCSEL = 10'b00_0001_0000;
  localparam logic [9:0] B_RET   = 10'b00_0000_1000;
  localparam logic [9:0] B_TRAP  = 10'b00_0000_0100;
  localparam logic [9:0] B_WBBASE = B_REGWE | B_PCWE | B_RET;

  typedef enum {M_ALU, M_LOAD, M_STORE, M_BRANCH, M_JUMP, M_BAD} mcls_t;
  typedef struct {
    logic       rdy;
    logic       tk;
    logic [9:0] exp;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        mem_ready, branch_taken;
  logic [4:0]  imm_type_o;
  logic        mem_req_o, mem_we_o, ir_we_o, reg_we_o, pc_we_o, pc_sel_o;
  logic        retire_o, trap_o;
  logic [1:0]  wb_sel_o;
  logic [2:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .inst_i         (inst),
    .mem_ready_i    (mem_ready),
    .branch_taken_i (branch_taken),
    .imm_type_o     (imm_type_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .ir_we_o        (ir_we_o),
    .reg_we_o       (reg_we_o),
    .pc_we_o        (pc_we_o),
    .pc_sel_o       (pc_sel_o),
    .retire_o       (retire_o),
    .trap_o         (trap_o),
    .wb_sel_o       (wb_sel_o),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {mem_req_o, mem_we_o, ir_we_o, reg_we_o, pc_we_o, pc_sel_o,
            retire_o, trap_o, wb_sel_o};
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic cyc_t mk(input logic rdy, input logic tk, input logic [9:0] e);
    cyc_t c;
    c.rdy = rdy;
    c.tk  = tk;
    c.exp = e;
    return c;
  endfunction

  function automatic mcls_t cls_of(input logic [6:0] opc);
    case (opc)
      7'b0000011:                                     return M_LOAD;
      7'b0100011:                                     return M_STORE;
      7'b1100011:                                     return M_BRANCH;
      7'b1101111, 7'b1100111:                         return M_JUMP;
      7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111: return M_ALU;
      default:                                        return M_BAD;
    endcase
  endfunction

  function automatic logic [4:0] imm_of(input logic [6:0] opc);
    case (opc)
      7'b0000011, 7'b0010011, 7'b1100111: return 5'b10000;
      7'b0100011:                         return 5'b01000;
      7'b1100011:                         return 5'b00100;
      7'b1101111:                         return 5'b00010;
      7'b0110111, 7'b0010111:             return 5'b00001;
      default:                            return 5'b00000;
    endcase
  endfunction

  // Reset with ready/taken high to show the outputs are gated; release
  // just after a rising edge so the next full cycle is the first FETCH.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1; branch_taken = 1'b1;
    #1;
    check("rst outs", 32'(outs()), 32'd0);
    check("rst state", 32'(state_o), 32'(ST_FETCH));
    check("rst imm", 32'(imm_type_o), 32'd0);
    @(posedge clk);
    #1;
    check("rst outs held", 32'(outs()), 32'd0);
    rst = 1'b0;
  endtask

  // fw / mw: wait cycles before ready in FETCH / MEM (>= TIMEOUT traps).
  task automatic run_instr(input string name, input logic [31:0] instr,
                           input int fw, input int mw, input logic taken);
    cyc_t  q[$];
    mcls_t cls     = cls_of(instr[6:0]);
    logic  st      = (cls == M_STORE);
    bit    trapped = 1'b0;
    bit    decoded = 1'b0;
    if (fw >= TIMEOUT) begin
      repeat (TIMEOUT) q.push_back(mk(1'b0, rb(), B_REQ));
      trapped = 1'b1;
    end else begin
      repeat (fw) q.push_back(mk(1'b0, rb(), B_REQ));
      q.push_back(mk(1'b1, rb(), B_REQ | B_IR));
      q.push_back(mk(rb(), rb(), 10'b0));
      if (cls == M_BAD) begin
        trapped = 1'b1;
      end else begin
        decoded = 1'b1;
        case (cls)
          M_BRANCH: q.push_back(mk(rb(), taken, B_PCWE | B_RET | (taken ? B_PCSEL : 10'b0)));
          M_LOAD, M_STORE: begin
            q.push_back(mk(rb(), rb(), 10'b0));
            if (mw >= TIMEOUT) begin
              repeat (TIMEOUT) q.push_back(mk(1'b0, rb(), B_REQ | (st ? B_WE : 10'b0)));
              trapped = 1'b1;
            end else begin
              repeat (mw) q.push_back(mk(1'b0, rb(), B_REQ | (st ? B_WE : 10'b0)));
              if (st) begin
                q.push_back(mk(1'b1, rb(), B_REQ | B_WE | B_PCWE | B_RET));
              end else begin
                q.push_back(mk(1'b1, rb(), B_REQ));
                q.push_back(mk(rb(), rb(), B_WBBASE | 10'b01));
              end
            end
          end
          M_JUMP: begin
            q.push_back(mk(rb(), rb(), 10'b0));
            q.push_back(mk(rb(), rb(), B_WBBASE | B_PCSEL | 10'b10));
          end
          default: begin
            q.push_back(mk(rb(), rb(), 10'b0));
            q.push_back(mk(rb(), rb(), B_WBBASE));
          end
        endcase
      end
    end
    if (trapped) repeat (20) q.push_back(mk(rb(), rb(), B_TRAP));

    foreach (q[i]) begin
      @(negedge clk);
      inst = instr; mem_ready = q[i].rdy; branch_taken = q[i].tk;
      #1;
      if (i == 0) check({name, " start state"}, 32'(state_o), 32'(ST_FETCH));
      check($sformatf("%s cyc%0d", name, i), 32'(outs()), 32'(q[i].exp));
    end
    if (decoded) check({name, " imm"}, 32'(imm_type_o), 32'(imm_of(instr[6:0])));
    if (trapped) do_reset();
  endtask

  // LW aborted by an asynchronous reset while waiting in MEM.
  task automatic reset_mid_mem();
    @(negedge clk);
    inst = 32'h00012083; mem_ready = 1'b1; branch_taken = 1'b0;
    #1 check("lwrst fetch", 32'(state_o), 32'(ST_FETCH));
    @(negedge clk); mem_ready = 1'b0;
    #1 check("lwrst decode", 32'(state_o), 32'(ST_DECODE));
    @(negedge clk);
    #1 check("lwrst exec", 32'(state_o), 32'(ST_EXEC));
    @(negedge clk);
    #1 check("lwrst mem", 32'(outs()), 32'(B_REQ));
    #2 rst = 1'b1; mem_ready = 1'b1;
    #1;
    check("lwrst async outs", 32'(outs()), 32'd0);
    check("lwrst async state", 32'(state_o), 32'(ST_FETCH));
    check("lwrst async imm", 32'(imm_type_o), 32'd0);
    @(negedge clk);
    #1 check("lwrst held outs", 32'(outs()), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("lwrst post req", 32'(mem_req_o), 32'd1);
  endtask

  initial begin
    logic [6:0]  opcs [9];
    logic [31:0] r;
    opcs = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
             7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111};
    rst = 1'b1; inst = '0; mem_ready = 1'b0; branch_taken = 1'b0;

    do_reset();
    run_instr("addi",       32'h00500093, 0, 0, 1'b0);
    run_instr("sw",         32'h00112223, 0, 3, 1'b0);
    run_instr("beq",        32'h00000463, 0, 0, 1'b1);
    run_instr("beq_nt",     32'h00000463, 1, 0, 1'b0);
    run_instr("lw",         32'h00012083, 0, 0, 1'b0);
    run_instr("jal",        32'h008000EF, 2, 0, 1'b0);
    run_instr("jalr",       32'h000080E7, 0, 0, 1'b0);
    run_instr("lui",        32'h123450B7, 0, 0, 1'b0);
    run_instr("illegal",    32'hFFFFFFFF, 0, 0, 1'b0);
    run_instr("fetch_to",   32'h00500093, TIMEOUT, 0, 1'b0);
    run_instr("fetch_edge", 32'h00500093, TIMEOUT - 1, 0, 1'b0);
    run_instr("mem_to",     32'h00012083, 0, TIMEOUT, 1'b0);
    run_instr("mem_edge",   32'h00012083, 0, TIMEOUT - 1, 1'b0);
    run_instr("st_edge",    32'h00112223, TIMEOUT - 1, TIMEOUT - 1, 1'b0);
    reset_mid_mem();
    run_instr("after_rst",  32'h00500093, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      r = $urandom();
      run_instr($sformatf("rnd%0d", n), {r[31:7], opcs[$urandom_range(0, 8)]},
                $urandom_range(0, TIMEOUT - 1), $urandom_range(0, TIMEOUT - 1), rb());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: maximum cycles a memory request may wait for mem_ready_i before trapping.
REQ-002 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port inst_i, input, 32: current instruction register contents.
REQ-005 SHALL have port mem_ready_i, input, 1: memory completion for the current request.
REQ-006 SHALL have port branch_taken_i, input, 1: ALU branch condition result.
REQ-007 SHALL have port imm_type_o, output, 5: one-hot immediate select for the immediate generator; bit4=I, bit3=S, bit2=B, bit1=J, bit0=U.
REQ-008 SHALL have ports mem_req_o, mem_we_o, ir_we_o, reg_we_o, pc_we_o, pc_sel_o, retire_o and trap_o, each output, 1:
- mem_req_o, mem_we_o: memory request and write.
- ir_we_o: instruction register load.
- reg_we_o: register-file write.
- pc_we_o: PC load.
- pc_sel_o: PC source, 0 = PC+4, 1 = ALU target.
- retire_o: instruction-complete pulse.
- trap_o: sticky fault.
REQ-009 SHALL have port wb_sel_o, output, 2: write-back source; 00 = ALU, 01 = memory, 10 = PC+4.
REQ-010 SHALL have port state_o, output, 3: current FSM state, for debug.

Function
REQ-011 SHALL implement the states FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-012 FETCH SHALL assert mem_req_o with mem_we_o=0. On mem_ready_i it SHALL pulse ir_we_o in the same cycle and go to DECODE the next cycle.
REQ-013 DECODE SHALL last one cycle and SHALL register imm_type_o from inst_i[6:0] as follows:
- LOAD 0000011, OP-IMM 0010011, JALR 1100111 -> 10000.
- STORE 0100011 -> 01000.
- BRANCH 1100011 -> 00100.
- JAL 1101111 -> 00010.
- LUI 0110111, AUIPC 0010111 -> 00001.
- OP 0110011 -> 00000.
REQ-014 Any other opcode in DECODE SHALL go to TRAP.
REQ-015 imm_type_o SHALL hold its registered value until the next DECODE.
REQ-016 EXEC SHALL branch on instruction class:
- LOAD/STORE -> MEM.
- BRANCH -> FETCH, with pc_we_o=1, pc_sel_o=branch_taken_i and retire_o=1.
- All others -> WB.
REQ-017 MEM SHALL assert mem_req_o, with mem_we_o=1 for STORE only, until mem_ready_i.
REQ-018 On mem_ready_i in MEM:
- LOAD SHALL go to WB.
- STORE SHALL go to FETCH with pc_we_o=1, pc_sel_o=0 and retire_o=1.
REQ-019 WB SHALL assert reg_we_o=1, pc_we_o=1 and retire_o=1, then go to FETCH. Per class:
- LOAD: wb_sel_o=01, pc_sel_o=0.
- JAL/JALR: wb_sel_o=10, pc_sel_o=1.
- All others: wb_sel_o=00, pc_sel_o=0.
REQ-020 Instruction latency with zero-wait memory SHALL be:
- BRANCH: 3 cycles.
- STORE and ALU/U/J types: 4 cycles.
- LOAD: 5 cycles.
REQ-021 A wait counter SHALL clear on entry to FETCH or MEM and SHALL increment each cycle that mem_req_o=1 and mem_ready_i=0.
REQ-022 When the wait counter reaches MEM_TIMEOUT, the FSM SHALL go to TRAP next cycle.
REQ-023 mem_ready_i arriving in the same cycle that the count reaches MEM_TIMEOUT SHALL complete normally; ready takes priority.
REQ-024 TRAP SHALL hold trap_o=1 with all other strobes 0, and SHALL leave only on reset.
REQ-025 mem_ready_i outside FETCH/MEM SHALL be ignored.
REQ-026 The one-cycle strobes (ir_we_o, pc_we_o, reg_we_o, retire_o) SHALL never assert for more than one cycle per state visit.

Reset
REQ-027 While rst_i=1, the state SHALL be FETCH, the counter 0, imm_type_o=00000, wb_sel_o=00, and all 1-bit outputs 0, including mem_req_o (gated by rst_i).
REQ-028 Reset asserted mid-operation SHALL abort immediately with no further strobes. The first cycle after deassertion SHALL be FETCH with mem_req_o=1.

Structure
REQ-029 Opcode constants, state encodings and the imm_type codes SHALL live in a shared package riscv_pkg, for use by the immediate generator and future decode blocks.
REQ-030 Opcode-to-class/imm_type mapping SHALL be a combinational sub-module inst_class_dec.
REQ-031 The FSM and the wait counter SHALL remain in multicycle_ctrl.

Verification
REQ-032 Reset, inst 0x00500093 (ADDI), ready every request -> FETCH-DECODE-EXEC-WB in 4 cycles; imm_type_o=10000; reg_we_o, pc_we_o, retire_o in WB; wb_sel_o=00.
REQ-033 Inst 0x00112223 (SW), ready delayed 3 cycles in MEM -> mem_req_o=mem_we_o=1 for 4 cycles; imm_type_o=01000; retire_o on the ready cycle; reg_we_o never 1.
REQ-034 Inst 0x00000463 (BEQ), branch_taken_i=1 -> imm_type_o=00100; EXEC pulses pc_we_o=1 and pc_sel_o=1; next state FETCH; 3 cycles total.
REQ-035 Inst 0xFFFFFFFF -> TRAP after DECODE; trap_o=1 persists and mem_req_o stays 0 for 20 cycles; rst_i clears it.
REQ-036 MEM_TIMEOUT=4, mem_ready_i held 0 in FETCH -> TRAP entered after 4 wait cycles. Repeating with ready on the 4th wait cycle -> normal DECODE.
REQ-037 rst_i pulsed asynchronously mid-MEM of a LW -> outputs 0 within the reset; no reg_we_o; FETCH with mem_req_o=1 on the first post-reset cycle.
